// File: rtl/conv_mac_engine.sv
// Pipelined signed MAC over N_TAPS-pixel windows, summing N_CH channel windows per output; CONV_MAC_RELU_EN clamps negative results.
// Last accept to out_valid is 3 cycles; in_ready drops after the last window and out_acc/out_valid hold until out_ready.
module conv_mac_engine #(
   parameter int N_TAPS = 9,
   parameter int DATA_W = 8,
   parameter int WGT_W  = 8,
   parameter int N_CH   = 3,
   parameter int ACC_W  = 24
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               wgt_load,
   input  logic [$clog2(N_TAPS*N_CH)-1:0]     wgt_idx,
   input  logic signed [WGT_W-1:0]            wgt_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [N_TAPS*DATA_W-1:0]           in_win,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic signed [ACC_W-1:0]            out_acc,
   output logic                               busy
);
   localparam int N_W    = N_TAPS * N_CH;
   localparam int IDX_W  = $clog2(N_W);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PROD_W = DATA_W + 1 + WGT_W;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   state_t                    state, state_nxt;
   logic signed [WGT_W-1:0]   wgt [N_W];
   logic signed [PROD_W-1:0]  prod_d [N_TAPS];
   logic signed [PROD_W-1:0]  prod_q [N_TAPS];
   logic signed [ACC_W-1:0]   tree_sum, acc, acc_final;
   logic [CH_W-1:0]           ch_cnt;
   logic                      s1_vld, s1_first, accept, ch_last;

   assign accept  = in_valid && in_ready;
   assign ch_last = (ch_cnt == CH_W'(N_CH - 1));

   // Write is gated on IDLE so a group never sees its weights change mid-flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_W; i++) wgt[i] <= '0;
      end else if (wgt_load && state == IDLE && ({1'b0, wgt_idx} < (IDX_W+1)'(N_W))) begin
         wgt[wgt_idx] <= wgt_data;
      end
   end

   always_comb begin
      for (int k = 0; k < N_TAPS; k++) begin
         prod_d[k] = PROD_W'($signed({1'b0, in_win[k*DATA_W +: DATA_W]}))
                   * PROD_W'(wgt[IDX_W'(int'(ch_cnt) * N_TAPS + k)]);
      end
   end

   always_comb begin
      tree_sum = '0;
      for (int k = 0; k < N_TAPS; k++) tree_sum = tree_sum + ACC_W'(prod_q[k]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s1_first <= 1'b0;
         for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
      end else begin
         s1_vld   <= accept;
         s1_first <= (ch_cnt == '0);
         if (accept) prod_q <= prod_d;
      end
   end

   // Channel 0 loads the accumulator so a stale sum can never leak into a new group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (state == HOLD && out_ready) begin
         acc <= '0;
      end else if (s1_vld) begin
         acc <= s1_first ? tree_sum : acc + tree_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_cnt <= '0;
      end else if (accept) begin
         ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (N_CH == 1) ? DRAIN : ACCUM;
         ACCUM:   if (accept && ch_last) state_nxt = DRAIN;
         DRAIN:   if (!s1_vld) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = rst_n && (state == IDLE || state == ACCUM);
      busy     = (state != IDLE);
   end

`ifdef CONV_MAC_RELU_EN
   assign acc_final = acc[ACC_W-1] ? '0 : acc;
`else
   assign acc_final = acc;
`endif

   // DRAIN exits once S1 is empty, i.e. the last window's S2 update has landed in acc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_acc   <= '0;
      end else if (state == DRAIN && !s1_vld) begin
         out_valid <= 1'b1;
         out_acc   <= acc_final;
      end else if (state == HOLD && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized self-checking bench for conv_mac_engine against a group-level arithmetic model.
// A second N_CH=1 instance covers the single-channel configuration.
module tb_conv_mac_engine;
   localparam int N_TAPS = 9;
   localparam int N_CH   = 3;
   localparam int N_W    = N_TAPS * N_CH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wgt_load = 1'b0;
   logic [4:0]  wgt_idx = '0;
   logic [7:0]  wgt_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [71:0] in_win = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_acc;
   logic        busy;

   logic        d1_wgt_load = 1'b0;
   logic [3:0]  d1_wgt_idx = '0;
   logic [7:0]  d1_wgt_data = '0;
   logic        d1_in_valid = 1'b0;
   logic        d1_in_ready;
   logic [71:0] d1_in_win = '0;
   logic        d1_out_valid;
   logic        d1_out_ready = 1'b0;
   logic [23:0] d1_out_acc;
   logic        d1_busy;

   int          checks = 0;
   int          failures = 0;
   int          wm [N_W];
   logic [71:0] grp [N_CH];

   always #5 clk = ~clk;

   conv_mac_engine #(.N_TAPS(9), .DATA_W(8), .WGT_W(8), .N_CH(3), .ACC_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .wgt_load(wgt_load), .wgt_idx(wgt_idx), .wgt_data(wgt_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win), .out_valid(out_valid),
      .out_ready(out_ready), .out_acc(out_acc), .busy(busy));

   conv_mac_engine #(.N_TAPS(9), .DATA_W(8), .WGT_W(8), .N_CH(1), .ACC_W(24)) dut1 (
      .clk(clk), .rst_n(rst_n), .wgt_load(d1_wgt_load), .wgt_idx(d1_wgt_idx), .wgt_data(d1_wgt_data),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_win(d1_in_win), .out_valid(d1_out_valid),
      .out_ready(d1_out_ready), .out_acc(d1_out_acc), .busy(d1_busy));

   // Group result: plain dot products over all channels, wrapped to 24 bits.
   function automatic logic [23:0] expect_out();
      int s = 0;
      logic [23:0] r;
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < N_TAPS; k++)
            s += int'(grp[c][k*8 +: 8]) * wm[c*N_TAPS + k];
      r = s[23:0];
`ifdef CONV_MAC_RELU_EN
      if (r[23]) r = '0;
`endif
      return r;
   endfunction

   task automatic write_wgt(input int idx, input logic [7:0] d);
      @(negedge clk);
      wgt_load = 1'b1; wgt_idx = 5'(idx); wgt_data = d;
      @(negedge clk);
      wgt_load = 1'b0;
      if (idx < N_W) wm[idx] = int'($signed(d));
   endtask

   task automatic load_weights(input bit rnd, input logic [7:0] val);
      for (int i = 0; i < 32; i++) write_wgt(i, rnd ? 8'($urandom) : val);
   endtask

   task automatic rand_pixels();
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < N_TAPS; k++) grp[c][k*8 +: 8] = 8'($urandom);
   endtask

   task automatic send_group(input int gap_ch, input int gap_len, input int stall,
                             input int wr_mode, input string name, output logic [23:0] got);
      logic [23:0] exp_v, held;
      int n;
      exp_v = expect_out();
      for (int c = 0; c < N_CH; c++) begin
         @(negedge clk);
         wgt_load = 1'b0;
         if (c == gap_ch && gap_len > 0) begin
            in_valid = 1'b0;
            repeat (gap_len) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1) begin
               failures++;
               $display("FAIL %s gap: busy=%b in_ready=%b required 1/1", name, busy, in_ready);
            end
         end
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready ch%0d: got %b required 1", name, c, in_ready);
         end
         in_valid = 1'b1; in_win = grp[c];
         if ((wr_mode == 1 && c == 1) || (wr_mode == 2 && c == 0)) begin
            wgt_load = 1'b1; wgt_idx = 5'd0; wgt_data = 8'd100;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; wgt_load = 1'b0;
      if (wr_mode == 2) wm[0] = 100;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s drain: in_ready=%b out_valid=%b required 0/0", name, in_ready, out_valid);
      end
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 3) begin
         failures++;
         $display("FAIL %s latency: got %0d cycles required 3", name, n);
      end
      checks++;
      if (out_acc !== exp_v) begin
         failures++;
         $display("FAIL %s out_acc: got %h required %h", name, out_acc, exp_v);
      end
      got  = out_acc;
      held = out_acc;
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_acc !== held || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s hold: out_valid=%b out_acc=%h in_ready=%b required 1/%h/0",
                     name, out_valid, out_acc, in_ready, held);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s release: out_valid=%b busy=%b in_ready=%b required 0/0/1",
                  name, out_valid, busy, in_ready);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N_W; i++) wm[i] = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_acc !== 24'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_acc=%h busy=%b required 0/0/0/0",
                  in_ready, out_valid, out_acc, busy);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || d1_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset release: in_ready=%b d1_in_ready=%b required 1/1", in_ready, d1_in_ready);
      end
   endtask

   task automatic test_legacy();
      int n;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         d1_wgt_load = 1'b1; d1_wgt_idx = 4'(i); d1_wgt_data = (i % 2 == 0) ? 8'd1 : 8'd0;
      end
      @(negedge clk);
      d1_wgt_load = 1'b0;
      for (int k = 0; k < N_TAPS; k++) d1_in_win[k*8 +: 8] = 8'd1;
      d1_in_valid = 1'b1;
      @(negedge clk);
      d1_in_valid = 1'b0;
      n = 1;
      while (d1_out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 3 || d1_out_acc !== 24'd5) begin
         failures++;
         $display("FAIL legacy: latency=%0d out_acc=%h required 3/000005", n, d1_out_acc);
      end
      d1_out_ready = 1'b1;
      @(negedge clk);
      d1_out_ready = 1'b0;
      checks++;
      if (d1_out_valid !== 1'b0 || d1_busy !== 1'b0) begin
         failures++;
         $display("FAIL legacy release: out_valid=%b busy=%b required 0/0", d1_out_valid, d1_busy);
      end
   endtask

   task automatic test_signed();
      logic [23:0] got, req;
`ifdef CONV_MAC_RELU_EN
      req = 24'd0;
`else
      req = 24'hFFE51B;
`endif
      load_weights(1'b0, 8'hFF);
      for (int c = 0; c < N_CH; c++) grp[c] = {72{1'b1}};
      send_group(-1, 0, 0, 0, "signed", got);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL signed const: got %h required %h", got, req);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] got;
      load_weights(1'b1, 8'd0);
      rand_pixels();
      send_group(-1, 0, 10, 0, "backpressure", got);
      rand_pixels();
      send_group(-1, 0, 0, 0, "after_bp", got);
   endtask

   task automatic test_gap();
      logic [23:0] got;
      load_weights(1'b0, 8'd2);
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < N_TAPS; k++) grp[c][k*8 +: 8] = 8'd10;
      send_group(2, 5, 0, 0, "gap", got);
      checks++;
      if (got !== 24'd540) begin
         failures++;
         $display("FAIL gap const: got %h required %h", got, 24'd540);
      end
   endtask

   task automatic test_weight_writes();
      logic [23:0] got;
      load_weights(1'b1, 8'd0);
      write_wgt(0, 8'd3);
      rand_pixels();
      send_group(-1, 0, 0, 1, "busy_write", got);
      rand_pixels();
      grp[0][7:0] = 8'd7;
      send_group(-1, 0, 0, 0, "busy_write_next", got);
      rand_pixels();
      grp[0][7:0] = 8'd9;
      send_group(-1, 0, 0, 2, "idle_write", got);
      rand_pixels();
      grp[0][7:0] = 8'd11;
      send_group(-1, 0, 0, 0, "idle_write_next", got);
   endtask

   task automatic test_back_to_back_random();
      logic [23:0] got;
      int gch;
      for (int it = 0; it < 6; it++) begin
         load_weights(1'b1, 8'd0);
         rand_pixels();
         gch = int'($urandom_range(0, 2)) - 1;
         if (gch == 0) gch = -1;
         send_group(gch, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0, "random", got);
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] got;
      load_weights(1'b1, 8'd0);
      rand_pixels();
      @(negedge clk);
      in_valid = 1'b1; in_win = grp[0];
      @(negedge clk);
      in_win = grp[1];
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_acc !== 24'd0) begin
         failures++;
         $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b out_acc=%h required 0/0/0/0",
                  out_valid, busy, in_ready, out_acc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N_W; i++) wm[i] = 0;
      rand_pixels();
      send_group(-1, 0, 0, 0, "reset_mid_new", got);
      checks++;
      if (got !== 24'd0) begin
         failures++;
         $display("FAIL reset_mid zero: got %h required 000000", got);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_legacy();
      test_signed();
      test_backpressure();
      test_gap();
      test_weight_writes();
      test_back_to_back_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Parametrised, pipelined multiply-accumulate engine for the CNN convolution datapath.
- Applies a runtime-loadable signed kernel to an N_TAPS-pixel window.
- Accumulates the results of N_CH consecutive windows, one per input channel, into one output value.
- Replaces the fixed-pattern combinational tap adder; sits between the window generator and the activation/pooling stage.

Parameters:
- N_TAPS, 9, pixels per window (3x3 kernel).
- DATA_W, 8, unsigned pixel width.
- WGT_W, 8, signed two's-complement weight width.
- N_CH, 3, windows (channels) accumulated per output.
- ACC_W, 24, signed accumulator/output width; must be >= DATA_W+WGT_W+1+clog2(N_TAPS*N_CH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wgt_load  in  1  weight write strobe.
- wgt_idx  in  clog2(N_TAPS*N_CH)  weight address = ch*N_TAPS+tap.
- wgt_data  in  WGT_W  signed weight value.
- in_valid  in  1  in_win valid.
- in_ready  out  1  engine accepts a window this cycle.
- in_win  in  N_TAPS*DATA_W  packed pixels; tap k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  out_acc valid.
- out_ready  in  1  downstream accepts out_acc.
- out_acc  out  ACC_W  signed accumulated result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ch_cnt=0, acc=0, all weights=0, pipeline valids=0, out_valid=0, out_acc=0, in_ready=0 while in reset.
- Weights: register file of N_TAPS*N_CH entries.
  - Written on wgt_load only when busy=0; the write is ignored otherwise.
  - An out-of-range wgt_idx is ignored.
  - A write is visible to a window accepted on the next cycle.
- Accept: a window is accepted when in_valid && in_ready. in_win is sampled with the current ch_cnt.
- Arithmetic:
  - Each pixel is zero-extended to DATA_W+1 bits signed.
  - product = pixel * w[ch*N_TAPS+k], signed.
  - The adder tree sign-extends each product to ACC_W.
  - acc wraps modulo 2^ACC_W; no saturation.
- Pipeline, for a window accepted at cycle t:
  - S1 at t+1: N_TAPS products registered.
  - S2 at t+2: tree sum added into acc. For ch=0 the sum is loaded rather than added.
  - One window per cycle is sustained within a channel group.
- FSM:
  - IDLE: in_ready=1. On accept go to ACCUM with ch_cnt=1, or to DRAIN if N_CH=1.
  - ACCUM: in_ready=1. Each accept increments ch_cnt. The accept of the window with ch=N_CH-1 moves to DRAIN and sets ch_cnt=0.
  - DRAIN: in_ready=0. Waits until the last window's S2 update is done, then out_acc<=final acc, out_valid<=1, state=HOLD.
  - HOLD: in_ready=0; out_acc stable. On out_valid && out_ready: out_valid<=0, acc<=0, state=IDLE. The next window can be accepted on the following cycle.
- Latency: last window accepted at t gives out_valid=1 at t+3.
- Backpressure: out_acc and out_valid hold indefinitely while out_ready=0.
- in_valid low mid-group: the FSM stays in ACCUM and ch_cnt is preserved. There is no timeout.
- Simultaneous wgt_load and accept in IDLE: the weight write is applied; the accepted window uses the old value of that entry.
- Reset mid-operation aborts the group. Partial sums, pending output and weights are all cleared.

Optional Feature:
- Macro: CONV_MAC_RELU_EN.
- Defined: at the DRAIN->HOLD transfer, a negative final acc is replaced with 0 in out_acc. The internal acc is unchanged.
- Undefined: out_acc carries the signed raw sum. Latency is identical in both builds.

Test Plan:
- Legacy check: N_CH=1, weights ch0 = 1,0,1,0,1,0,1,0,1, all pixels=1 -> out_acc=5, out_valid exactly 3 cycles after accept.
- Signed multi-channel: N_CH=3, all weights=-1, all pixels=255, windows back-to-back -> out_acc=-6885 (0xFFE51B); with CONV_MAC_RELU_EN -> 0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid held, out_acc stable, in_ready=0; release -> IDLE, next group accepted one cycle after the handshake.
- Gap in channel group: stall in_valid 5 cycles between ch1 and ch2 (weights=2, pixels=10) -> out_acc=540, unaffected by the gap.
- Weight load while busy: wgt_load with idx=0, data=100 during ACCUM -> write ignored, weight reads back unchanged on the next group's result.
- Reset mid-group: rst_n pulsed low after ch1 accept -> out_valid=0, busy=0, weights zero; a new group with zero weights -> out_acc=0.
